// File: rtl/fpu_result_collector.sv
// fpu_result_collector: buffers FPU add/sub results and flags in a FIFO and keeps sticky exception flags
module fpu_result_collector #(
   parameter int e_p   = 8,
   parameter int m_p   = 23,
   parameter int els_p = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       fpu_v_i,
   input  logic [e_p+m_p:0]           fpu_z_i,
   input  logic [3:0]                 fpu_flags_i,
   output logic                       fpu_yumi_o,
   output logic                       v_o,
   output logic [e_p+m_p:0]           data_o,
   output logic [3:0]                 flags_o,
   input  logic                       ready_and_i,
   input  logic                       clear_flags_i,
   output logic [3:0]                 sticky_flags_o,
   output logic [$clog2(els_p+1)-1:0] count_o
);
   localparam int w  = e_p + m_p + 1;
   localparam int pw = $clog2(els_p);
   localparam int cw = $clog2(els_p + 1);
   logic [w+3:0]  mem [els_p];
   logic [pw-1:0] wptr, rptr;
   logic [cw-1:0] count;
   logic          full, deq;
   assign full           = count == cw'(els_p);
   assign v_o            = count != '0;
   assign deq            = v_o & ready_and_i;
   // gated by reset so no handshake completes while reset is asserted
   assign fpu_yumi_o     = fpu_v_i & ~full & reset_n_i;
   assign data_o         = mem[rptr][w-1:0];
   assign flags_o        = mem[rptr][w+3:w];
   assign count_o        = count;
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < els_p; i++) mem[i] <= '0;
         wptr           <= '0;
         rptr           <= '0;
         count          <= '0;
         sticky_flags_o <= '0;
      end else begin
         if (fpu_yumi_o) mem[wptr] <= {fpu_flags_i, fpu_z_i};
         wptr           <= wptr + pw'(fpu_yumi_o);
         rptr           <= rptr + pw'(deq);
         count          <= count + cw'(fpu_yumi_o) - cw'(deq);
         sticky_flags_o <= (clear_flags_i ? 4'b0 : sticky_flags_o) | (fpu_yumi_o ? fpu_flags_i : 4'b0);
      end
   end
endmodule

// File: tb/tb_fpu_result_collector.sv
// tb_fpu_result_collector: directed and random checks of the result collector against a queue model
module tb_fpu_result_collector;
   logic        clk = 0, reset_n = 0;
   logic        fpu_v = 0, ready = 0, clr = 0;
   logic [31:0] fpu_z = 0;
   logic [3:0]  fpu_fl = 0;
   logic        yumi, v_o;
   logic [31:0] data_o;
   logic [3:0]  flags_o, sticky;
   logic [2:0]  count;
   int          total = 0, bad = 0;
   logic [35:0] q[$];
   logic [3:0]  m_sticky = 0;
   logic        last_yumi;

   fpu_result_collector dut (
      .clk_i(clk), .reset_n_i(reset_n), .fpu_v_i(fpu_v), .fpu_z_i(fpu_z),
      .fpu_flags_i(fpu_fl), .fpu_yumi_o(yumi), .v_o(v_o), .data_o(data_o),
      .flags_o(flags_o), .ready_and_i(ready), .clear_flags_i(clr),
      .sticky_flags_o(sticky), .count_o(count));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one cycle: drive at negedge, check against model, apply model at the edge
   task automatic cyc(input logic v, input logic [31:0] z, input logic [3:0] fl,
                      input logic rdy, input logic c);
      logic ey, ev;
      @(negedge clk);
      fpu_v = v; fpu_z = z; fpu_fl = fl; ready = rdy; clr = c;
      #1;
      ey = v && (q.size() < 4);
      ev = q.size() > 0;
      chk("yumi", yumi, ey);
      chk("v_o", v_o, ev);
      chk("count", count, q.size());
      chk("sticky", sticky, m_sticky);
      if (ev) begin
         chk("data", data_o, q[0][31:0]);
         chk("flags", flags_o, q[0][35:32]);
      end
      if (ev && rdy) void'(q.pop_front());
      if (ey) q.push_back({fl, z});
      m_sticky = (c ? 4'b0 : m_sticky) | (ey ? fl : 4'b0);
      last_yumi = ey;
      @(posedge clk);
      #1;
      fpu_v = 0; ready = 0; clr = 0;
   endtask

   initial begin
      int sent;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_v", v_o, 0);
      chk("rst_cnt", count, 0);
      chk("rst_data", data_o, 0);
      chk("rst_flags", flags_o, 0);
      chk("rst_sticky", sticky, 0);
      fpu_v = 1; #1;
      chk("rst_yumi", yumi, 0);
      fpu_v = 0;
      @(negedge clk); reset_n = 1;
      // single result
      cyc(1, 32'h40C00000, 0, 1, 0);
      chk("single_yumi", last_yumi, 1);
      chk("single_v", v_o, 1);
      chk("single_data", data_o, 32'h40C00000);
      chk("single_cnt", count, 1);
      cyc(0, 0, 0, 1, 0);
      chk("single_drain", count, 0);
      // fill to full
      for (int i = 0; i < 4; i++) cyc(1, 32'h3F800000 + i, 0, 0, 0);
      chk("full_cnt", count, 4);
      cyc(1, 32'h3F800004, 0, 0, 0);
      chk("full_refuse", last_yumi, 0);
      sent = 0;
      for (int i = 0; i < 8 && !sent; i++) begin
         cyc(1, 32'h3F800004, 0, 1, 0);
         if (last_yumi) sent = 1;
      end
      chk("fifth_accepted", sent, 1);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
      chk("full_drain", count, 0);
      // wrap-around stream with toggling ready; the FPU holds an unaccepted result
      sent = 0;
      for (int i = 0; i < 200 && sent < 20; i++) begin
         cyc(1, 32'hA0000000 + sent, 0, i[0], 0);
         chk("cnt_le4", count <= 4, 1);
         if (last_yumi) sent++;
      end
      chk("stream_sent", sent, 20);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
      chk("stream_drain", count, 0);
      // sticky flags
      cyc(1, 32'h7F800000, 4'b0010, 1, 0);
      chk("stk_ovf", sticky, 4'b0010);
      cyc(1, 32'h7F800001, 4'b0100, 1, 0);
      chk("stk_or", sticky, 4'b0110);
      cyc(0, 0, 0, 1, 1);
      chk("stk_clear", sticky, 4'b0000);
      cyc(1, 32'h00000001, 4'b0001, 1, 1);
      chk("stk_clear_acc", sticky, 4'b0001);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
      // randomized traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), $urandom, 4'($urandom),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
      // reset mid-stream
      cyc(0, 0, 0, 0, 1);
      cyc(1, 32'h11111111, 4'b1000, 0, 0);
      cyc(1, 32'h22222222, 0, 0, 0);
      cyc(1, 32'h33333333, 0, 0, 0);
      chk("pre_rst_cnt", count, 3);
      chk("pre_rst_stk", sticky, 4'b1000);
      fpu_v = 1; reset_n = 0;
      #1;
      chk("mid_rst_v", v_o, 0);
      chk("mid_rst_cnt", count, 0);
      chk("mid_rst_stk", sticky, 0);
      chk("mid_rst_yumi", yumi, 0);
      #1 reset_n = 1; fpu_v = 0;
      q.delete();
      m_sticky = 0;
      cyc(1, 32'h40000000, 0, 0, 0);
      chk("post_rst_v", v_o, 1);
      chk("post_rst_data", data_o, 32'h40000000);
      cyc(0, 0, 0, 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
